mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between IF and LS.
// Optional macro MEM_PORT_ARB_RR_EN selects round-robin instead of LS priority.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;
  localparam logic [1:0] LAT_LAST = RD_LAT[1:0];

  state_t            state;
  state_t            state_d;
  logic [1:0]        lat_cnt;
  logic [1:0]        lat_d;
  logic              owner;
  logic              owner_d;
  logic              pick_ls;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              wren_d;
  logic              if_gnt_d;
  logic              ls_gnt_d;
  logic              if_rv_d;
  logic              ls_rv_d;
  logic [DATA_W-1:0] if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_d;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_owner;

  // Remember who was granted last so contention alternates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_LS;
    end else if (if_gnt_d | ls_gnt_d) begin
      last_owner <= owner_d;
    end
  end

  // LS wins alone, or on contention when IF was granted last.
  assign pick_ls = ls_req & (~if_req | (last_owner == OWN_IF));
`else
  // LS always beats IF.
  assign pick_ls = ls_req;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
      owner   <= OWN_IF;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
      owner   <= owner_d;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state;
    lat_d      = lat_cnt;
    owner_d    = owner;
    addr_d     = ram_address;
    data_d     = ram_data;
    wren_d     = 1'b0;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    if_rv_d    = 1'b0;
    ls_rv_d    = 1'b0;
    if_rdata_d = if_rdata;
    ls_rdata_d = ls_rdata;
    unique case (state)
      IDLE: begin
        if (if_req | ls_req) begin
          owner_d  = pick_ls;
          state_d  = ACCESS;
          ls_gnt_d = pick_ls;
          if_gnt_d = ~pick_ls;
          if (pick_ls) begin
            addr_d = ls_addr;
            data_d = ls_wdata;
            wren_d = ls_we;
          end else begin
            addr_d = if_addr;
          end
        end
      end
      ACCESS: begin
        if (ram_wren) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = 2'd1;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_d = IDLE;
          lat_d   = 2'd0;
          if (owner == OWN_LS) begin
            ls_rv_d    = 1'b1;
            ls_rdata_d = ram_q;
          end else begin
            if_rv_d    = 1'b1;
            if_rdata_d = ram_q;
          end
        end else begin
          lat_d = lat_cnt + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = 2'd0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      if_gnt      <= 1'b0;
      ls_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      ls_rvalid   <= 1'b0;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      ram_address <= addr_d;
      ram_data    <= data_d;
      ram_wren    <= wren_d;
      if_gnt      <= if_gnt_d;
      ls_gnt      <= ls_gnt_d;
      if_rvalid   <= if_rv_d;
      ls_rvalid   <= ls_rv_d;
      if_rdata    <= if_rdata_d;
      ls_rdata    <= ls_rdata_d;
      busy        <= (state_d != IDLE);
    end
  end

  // Grants and read returns are mutually exclusive.
  a_one_gnt: assert property (
    @(posedge clk) disable iff (rst) !(if_gnt && ls_gnt));
  a_one_rv: assert property (
    @(posedge clk) disable iff (rst) !(if_rvalid && ls_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Covers reset, IF/LS access, arbitration, mid-read reset and RD_LAT=3.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic       if_req, ls_req, ls_we;
  logic [7:0] if_addr, ls_addr, ls_wdata;
  logic       if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [7:0] if_rdata, ls_rdata;
  logic [7:0] ram_address, ram_data, ram_q;
  logic       ram_wren, busy;

  logic       if_req3, ls_req3, ls_we3;
  logic [7:0] if_addr3, ls_addr3, ls_wdata3;
  logic       if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3;
  logic [7:0] if_rdata3, ls_rdata3;
  logic [7:0] ram_address3, ram_data3, ram_q3;
  logic       ram_wren3, busy3;

  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3),
    .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3),
    .ls_wdata(ls_wdata3), .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3),
    .ls_rdata(ls_rdata3), .ram_address(ram_address3),
    .ram_data(ram_data3), .ram_wren(ram_wren3), .ram_q(ram_q3),
    .busy(busy3)
  );

  // RAM model, latency 1, with a bench preload port.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // RAM model, latency 3.
  logic [7:0] mem3 [256];
  logic [7:0] p0, p1;
  always @(posedge clk) begin
    if (pre_we) mem3[pre_addr] <= pre_data;
    else if (ram_wren3) mem3[ram_address3] <= ram_data3;
    p0     <= mem3[ram_address3];
    p1     <= p0;
    ram_q3 <= p1;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_gnt(input bit use_ls, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (use_ls ? ls_gnt : if_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
         ram_address, ram_data, ram_wren, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b/%b rv=%b/%b wren=%b busy=%b addr=%h, need all 0",
               if_gnt, ls_gnt, if_rvalid, ls_rvalid, ram_wren, busy, ram_address);
    end
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({if_gnt, ls_gnt, busy, ram_wren} !== 4'b0) begin
        n_bad++;
        $display("FAIL idle_no_req: got gnt=%b/%b busy=%b wren=%b, need 0",
                 if_gnt, ls_gnt, busy, ram_wren);
      end
    end
  endtask

  task automatic test_if_read();
    bit ok;
    preload(8'h05, 8'hA5);
    if_addr = 8'h05; if_req = 1'b1;
    wait_gnt(1'b0, ok);
    n_vec++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL if_gnt: got no grant, need grant within 20 cycles");
    end
    n_vec++;
    if ({ram_address, ram_wren} !== {8'h05, 1'b0}) begin
      n_bad++;
      $display("FAIL if_access: got addr=%h wren=%b, need 05/0", ram_address, ram_wren);
    end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_rvalid, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL if_wait: got rvalid=%b busy=%b, need 0/1", if_rvalid, busy);
    end
    @(negedge clk);
    n_vec++;
    if ({if_rvalid, if_rdata, busy, ls_rvalid} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL if_rdata: got rvalid=%b data=%h busy=%b ls_rv=%b, need 1/a5/0/0",
               if_rvalid, if_rdata, busy, ls_rvalid);
    end
    @(negedge clk);
    n_vec++;
    if ({if_rvalid, if_rdata} !== {1'b0, 8'hA5}) begin
      n_bad++;
      $display("FAIL if_hold: got rvalid=%b data=%h, need 0/a5", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_ls_write_read();
    bit ok;
    ls_addr = 8'h10; ls_wdata = 8'h3C; ls_we = 1'b1; ls_req = 1'b1;
    wait_gnt(1'b1, ok);
    n_vec++;
    if ({ok, ram_wren, ram_address, ram_data} !== {1'b1, 1'b1, 8'h10, 8'h3C}) begin
      n_bad++;
      $display("FAIL ls_write_access: got gnt=%b wren=%b addr=%h data=%h, need 1/1/10/3c",
               ok, ram_wren, ram_address, ram_data);
    end
    @(posedge clk); #1 ls_req = 1'b0; ls_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ram_wren, ls_rvalid, busy, ls_gnt} !== 4'b0) begin
        n_bad++;
        $display("FAIL ls_write_done: got wren=%b rv=%b busy=%b gnt=%b, need 0",
                 ram_wren, ls_rvalid, busy, ls_gnt);
      end
    end
    ls_req = 1'b1;
    wait_gnt(1'b1, ok);
    n_vec++;
    if ({ok, ram_wren} !== 2'b10) begin
      n_bad++;
      $display("FAIL ls_read_gnt: got gnt=%b wren=%b, need 1/0", ok, ram_wren);
    end
    @(posedge clk); #1 ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({ls_rvalid, ls_rdata, if_rvalid} !== {1'b1, 8'h3C, 1'b0}) begin
      n_bad++;
      $display("FAIL ls_read_data: got rv=%b data=%h if_rv=%b, need 1/3c/0",
               ls_rvalid, ls_rdata, if_rvalid);
    end
  endtask

  task automatic test_contention();
    int got [4];
    int exp_own [4];
    int k;
`ifdef MEM_PORT_ARB_RR_EN
    exp_own = '{0, 1, 0, 1};
`else
    exp_own = '{1, 1, 1, 1};
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    k = 0;
    if_addr = 8'h10; ls_addr = 8'h05; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      if (if_gnt && ls_gnt) begin
        n_vec++; n_bad++;
        $display("FAIL dual_gnt: got both grants high, need at most one");
      end
      if (ls_gnt) begin got[k] = 1; k++; end
      else if (if_gnt) begin got[k] = 0; k++; end
    end
    @(posedge clk); #1 if_req = 1'b0; ls_req = 1'b0;
    n_vec++;
    if (k != 4) begin
      n_bad++;
      $display("FAIL arb_count: got %0d grants, need 4", k);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i < k && got[i] != exp_own[i]) begin
        n_bad++;
        $display("FAIL arb_order[%0d]: got owner %0d, need %0d (0=IF 1=LS)",
                 i, got[i], exp_own[i]);
      end
    end
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL arb_drain: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_rst_mid_read();
    bit ok;
    if_addr = 8'h05; if_req = 1'b1;
    wait_gnt(1'b0, ok);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ok, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_pre_wait: got gnt=%b busy=%b, need 1/1", ok, busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({if_rvalid, if_rdata, ls_rdata, ram_wren, busy, if_gnt} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got rv=%b rdata=%h/%h wren=%b busy=%b, need 0",
               if_rvalid, if_rdata, ls_rdata, ram_wren, busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({if_rvalid, ls_rvalid, ram_wren, busy} !== 4'b0) begin
        n_bad++;
        $display("FAIL rst_drop: got rv=%b/%b wren=%b busy=%b, need 0",
                 if_rvalid, ls_rvalid, ram_wren, busy);
      end
    end
  endtask

  task automatic test_rd_lat3();
    bit ok;
    ok = 1'b0;
    preload(8'h7F, 8'h11);
    if_addr3 = 8'h7F; if_req3 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt3) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL lat3_gnt: got no grant, need grant within 20 cycles");
    end
    @(posedge clk); #1 if_req3 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({if_rvalid3, busy3} !== 2'b01) begin
        n_bad++;
        $display("FAIL lat3_wait[A+%0d]: got rv=%b busy=%b, need 0/1",
                 i, if_rvalid3, busy3);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({if_rvalid3, if_rdata3, busy3} !== {1'b1, 8'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL lat3_data: got rv=%b data=%h busy=%b, need 1/11/0",
               if_rvalid3, if_rdata3, busy3);
    end
  endtask

  initial begin
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    if_req3 = 1'b0; ls_req3 = 1'b0; ls_we3 = 1'b0;
    if_addr3 = '0; ls_addr3 = '0; ls_wdata3 = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_if_read();
    test_ls_write_read();
    test_contention();
    test_rst_mid_read();
    test_rd_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before 200us");
    $fatal(1);
  end

endmodule
